uart_rx_ovs: RTL and testbench
==============================

// Module: uart_rx_ovs
// PURPOSE
//  Parametrised UART receiver, successor of the single-byte receiver: oversampled majority-vote sampling,
//  configurable data/stop width, optional parity, framing/overrun/break detection, FIFO-buffered output.
//  Sits between the RXD pad and any bus-side consumer; consumer drains bytes via VALID/READY.
// PARAMETERS
//  Fclk   12_000_000  system clock frequency, Hz
//  Bauds  115_200     line rate, bit/s
//  Wdata  8           data bits per frame (5..9)
//  Wstop  1           stop bits per frame (1..2)
//  Novs   16          oversampling ticks per bit (even, >=8)
//  Depth  16          FIFO entries (power of two, >=2)
//  Parity 0           0 even, 1 odd (used only with UART_RX_PARITY_EN)
// PORTS
//  CLK    in   1              system clock
//  RST    in   1              synchronous, active-high reset
//  RXD    in   1              asynchronous serial line, idle high
//  DOUT   out  Wdata          FIFO head data (first-word fall-through)
//  FERR   out  1              FIFO head framing error flag
//  PERR   out  1              FIFO head parity error flag (tied 0 without UART_RX_PARITY_EN)
//  VALID  out  1              FIFO non-empty
//  READY  in   1              consumer pop; pop occurs on VALID && READY
//  COUNT  out  $clog2(Depth)+1 entries held
//  OVR    out  1              1-cycle pulse: frame dropped, FIFO full
//  BRK    out  1              1-cycle pulse: break condition detected
//  INT    out  1              registered VALID|OVR|BRK
// BEHAVIOUR
//  Clock: one clock CLK; reset RST synchronous active-high. All outputs 0 in reset; synchroniser regs reset to 1.
//  RXD through 2-FF synchroniser; all logic below uses synced value.
//  Tick gen: counter of Ntick=Fclk/(Bauds*Novs) clocks (integer, truncated); tick pulse 1 cycle; runs only outside IDLE.
//  FSM IDLE -> START -> DATA -> [PAR] -> STOP -> IDLE; per-state bit counter counts Novs ticks per bit.
//  IDLE: synced RXD 1->0 -> START, tick counter cleared.
//  Sampling: 3 samples at ticks Novs/2-1, Novs/2, Novs/2+1 of each bit; bit value = majority.
//  START: majority 1 -> false start, back to IDLE, nothing pushed.
//  DATA: Wdata bits, LSB first, into shift register.
//  PAR (macro only): majority vs computed parity; mismatch sets perr.
//  STOP: each of Wstop bits must be 1, else ferr set. Frame complete at mid-sample of last stop bit
//  (no wait for full stop period; IDLE re-entered immediately so back-to-back frames are accepted).
//  Push {perr,ferr,data}: one cycle after last stop mid-sample; VALID rises that same cycle if FIFO was empty.
//  Break: data all 0, ferr set, (parity bit 0) -> BRK pulse, nothing pushed; FSM waits in IDLE-hold until RXD=1.
//  FIFO full on push: frame dropped, OVR pulses, contents unchanged. Push and pop same cycle when full: both honoured.
//  Pop on empty: ignored. COUNT never exceeds Depth; pointers wrap modulo Depth.
//  RST mid-frame: frame discarded, FIFO emptied, FSM to IDLE, no pulses emitted.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PAR state present, Parity parameter honoured, PERR live, FIFO entry Wdata+2 wide.
//  Not defined: no PAR state, frame = 1+Wdata+Wstop, PERR constant 0, FIFO entry Wdata+1 wide.
// STRUCTURE
//  Package uart_pkg: rx_state_t enum (IDLE, START, DATA, PAR, STOP, HOLD), majority3() function,
//  ticks_per_sample(Fclk,Bauds,Novs) constant function. Shared with future TX successor.
//  Sub-module uart_rx_fifo: parametrised Depth x width FWFT FIFO with push/pop/count/full; rest in uart_rx_ovs.
// TESTING
//  Fclk=12e6, Bauds=187_500, Novs=16 (4 clk/tick, 64 clk/bit), Wdata=8, Wstop=1, Depth=4.
//  1 Byte 0xA5 sent, READY=0 -> VALID=1, DOUT=0xA5, FERR=0, COUNT=1, INT=1; 1 clk after stop mid-sample.
//  2 Glitch: RXD low 20 clk then high -> false start, VALID stays 0, FSM back to IDLE.
//  3 Byte 0x3C with stop bit 0 then line high -> DOUT=0x3C, FERR=1; next byte 0x55 received cleanly.
//  4 Six bytes 0x01..0x06 back-to-back, READY=0 -> COUNT=4, OVR pulses twice, DOUT pops 0x01..0x04.
//  5 RXD low for 20 bit times -> BRK single pulse, no push; byte 0x7E after RXD high received OK.
//  6 RST asserted mid-DATA of 0xFF with 2 bytes queued -> COUNT=0, VALID=0; next frame 0x81 received.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state type and helpers shared by the UART receiver (and its future transmitter sibling).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        HOLD
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Clocks per oversampling tick; integer division truncates.
    function automatic int ticks_per_sample(input int fclk, input int bauds, input int novs);
        return fclk / (bauds * novs);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: Depth x Width first-word-fall-through FIFO; the head reads as zero while empty.
module uart_rx_fifo #(
    parameter int Depth = 16,
    parameter int Width = 9
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int Aw = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wr_ptr_q;
    logic [Aw-1:0]    rd_ptr_q;
    logic [Aw:0]      count_q;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == (Aw+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign rd_en   = pop_i && !empty_o;
    // A push into a full FIFO is still taken when a pop frees the head slot in the same cycle.
    assign wr_en   = push_i && (!full_o || rd_en);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + Aw'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + Aw'(1);
            count_q <= count_q + {{Aw{1'b0}}, wr_en} - {{Aw{1'b0}}, rd_en};
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampled majority-vote UART receiver with framing/overrun/break detection and FIFO output.
// Define UART_RX_PARITY_EN to add a parity bit per frame (Parity: 0 even, 1 odd) and a live PERR flag.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int Fclk   = 12_000_000,
    parameter int Bauds  = 115_200,
    parameter int Wdata  = 8,
    parameter int Wstop  = 1,
    parameter int Novs   = 16,
    parameter int Depth  = 16,
    parameter int Parity = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rxd_i,
    output logic [Wdata-1:0]       dout_o,
    output logic                   ferr_o,
    output logic                   perr_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [$clog2(Depth):0] count_o,
    output logic                   ovr_o,
    output logic                   brk_o,
    output logic                   int_o
);
    localparam int Ntick = ticks_per_sample(Fclk, Bauds, Novs);
    localparam int DivW  = (Ntick > 1) ? $clog2(Ntick) : 1;
    localparam int SubW  = $clog2(Novs);
    localparam int BitW  = $clog2(Wdata);
`ifdef UART_RX_PARITY_EN
    localparam int Went  = Wdata + 2;
`else
    localparam int Went  = Wdata + 1;
`endif

    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_t        state_q;
    logic [DivW-1:0]  div_q;
    logic [SubW-1:0]  sub_q;
    logic [BitW-1:0]  bit_q;
    logic [1:0]       samp_q;
    logic [Wdata-1:0] shift_q;
    logic             ferr_q;
    logic             push_q, brk_pend_q;
    logic [Went-1:0]  entry_q;
    logic             ovr_q, brk_q, int_q;
`ifdef UART_RX_PARITY_EN
    logic             perr_q, par_bit_q;
`endif

    logic             running, tick, bit_mid, bit_end, bit_val, stop_ferr, frame_brk;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [Went-1:0]  fifo_data;

    assign running   = (state_q != IDLE) && (state_q != HOLD);
    assign tick      = running && (div_q == DivW'(Ntick - 1));
    // A bit is decided on its third sample, so "mid-sample" below means tick Novs/2+1.
    assign bit_mid   = tick && (sub_q == SubW'(Novs/2 + 1));
    assign bit_end   = tick && (sub_q == SubW'(Novs - 1));
    assign bit_val   = majority3(samp_q[0], samp_q[1], rxd_sync_q);
    assign stop_ferr = ferr_q || !bit_val;
`ifdef UART_RX_PARITY_EN
    assign frame_brk = (shift_q == '0) && stop_ferr && !par_bit_q;
`else
    assign frame_brk = (shift_q == '0) && stop_ferr;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= IDLE;
            div_q      <= '0;
            sub_q      <= '0;
            bit_q      <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            ferr_q     <= 1'b0;
            push_q     <= 1'b0;
            brk_pend_q <= 1'b0;
            entry_q    <= '0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            push_q     <= 1'b0;
            brk_pend_q <= 1'b0;

            if (!running) begin
                div_q <= '0;
                sub_q <= '0;
            end else if (tick) begin
                div_q <= '0;
                sub_q <= bit_end ? '0 : sub_q + SubW'(1);
            end else begin
                div_q <= div_q + DivW'(1);
            end
            if (tick && sub_q == SubW'(Novs/2 - 1)) samp_q[0] <= rxd_sync_q;
            if (tick && sub_q == SubW'(Novs/2))     samp_q[1] <= rxd_sync_q;

            case (state_q)
                IDLE: begin
                    bit_q  <= '0;
                    ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_q <= 1'b0;
`endif
                    if (rxd_prev_q && !rxd_sync_q) state_q <= START;
                end
                START: begin
                    if (bit_mid && bit_val) state_q <= IDLE;
                    else if (bit_end)       state_q <= DATA;
                end
                DATA: begin
                    if (bit_mid) shift_q <= {bit_val, shift_q[Wdata-1:1]};
                    if (bit_end) begin
                        if (bit_q == BitW'(Wdata - 1)) begin
                            bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= PAR;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q <= bit_q + BitW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PAR: begin
                    if (bit_mid) begin
                        par_bit_q <= bit_val;
                        perr_q    <= bit_val != ((^shift_q) ^ (Parity != 0));
                    end
                    if (bit_end) state_q <= STOP;
                end
`endif
                STOP: begin
                    if (bit_mid) begin
                        ferr_q <= stop_ferr;
                        if (bit_q == BitW'(Wstop - 1)) begin
                            if (frame_brk) begin
                                brk_pend_q <= 1'b1;
                                state_q    <= HOLD;
                            end else begin
                                push_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                entry_q <= {perr_q, stop_ferr, shift_q};
`else
                                entry_q <= {stop_ferr, shift_q};
`endif
                                state_q <= IDLE;
                            end
                        end
                    end else if (bit_end) begin
                        bit_q <= bit_q + BitW'(1);
                    end
                end
                HOLD: begin
                    if (rxd_sync_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_pop = ready_i && !fifo_empty;

    uart_rx_fifo #(
        .Depth (Depth),
        .Width (Went)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_q),
        .data_i  (entry_q),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovr_q <= 1'b0;
            brk_q <= 1'b0;
            int_q <= 1'b0;
        end else begin
            ovr_q <= push_q && fifo_full && !fifo_pop;
            brk_q <= brk_pend_q;
            int_q <= !fifo_empty || ovr_q || brk_q;
        end
    end

    assign valid_o = !fifo_empty;
    assign dout_o  = fifo_data[Wdata-1:0];
    assign ferr_o  = fifo_data[Wdata];
`ifdef UART_RX_PARITY_EN
    assign perr_o  = fifo_data[Wdata+1];
`else
    assign perr_o  = 1'b0;
`endif
    assign ovr_o   = ovr_q;
    assign brk_o   = brk_q;
    assign int_o   = int_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: frame-level queue model compared every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_uart_rx_ovs;
    localparam int FCLK        = 12_000_000;
    localparam int BAUDS       = 187_500;
    localparam int NOVS        = 16;
    localparam int WDATA       = 8;
    localparam int WSTOP       = 1;
    localparam int DEPTH       = 4;
    localparam int CLK_PER_BIT = FCLK / BAUDS;
    // Line falls before edge k; START is entered at k+2 (two sync flops, edge detect), ticks follow every
    // 4 clocks, the last stop bit is decided on its third sample and the entry lands one clock later.
    localparam int PUSH_LAT    = 2 + (FCLK / (BAUDS * NOVS)) * ((WDATA + WSTOP) * NOVS + NOVS/2 + 2) + 1;

    typedef struct {
        int         cyc;
        logic       brk;
        logic       ferr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_i, rxd_i, ready_i;
    logic [7:0] dout_o;
    logic       ferr_o, perr_o, valid_o, ovr_o, brk_o, int_o;
    logic [2:0] count_o;

    uart_rx_ovs #(
        .Fclk (FCLK), .Bauds (BAUDS), .Wdata (WDATA), .Wstop (WSTOP),
        .Novs (NOVS), .Depth (DEPTH), .Parity (0)
    ) dut (
        .clk_i (clk), .rst_i (rst_i), .rxd_i (rxd_i),
        .dout_o (dout_o), .ferr_o (ferr_o), .perr_o (perr_o), .valid_o (valid_o),
        .ready_i (ready_i), .count_o (count_o), .ovr_o (ovr_o), .brk_o (brk_o), .int_o (int_o)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic       rdy_edge = 1'b0;
    logic       rst_edge = 1'b0;
    ev_t        ev_q[$];
    logic [8:0] m_q[$];
    logic       m_ovr = 1'b0, m_brk = 1'b0, m_int = 1'b0;
    logic       c_pop, c_full, c_nint;
    ev_t        c_ev;
    logic [31:0] exp_vec, act_vec;
    int         ovr_seen = 0, brk_seen = 0, rise_cyc = 0;
    logic       last_valid = 1'b0;
    logic [7:0] last_dout = '0;
    logic [7:0] pop_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_event(input int at, input logic brk, input logic ferr, input logic [7:0] data);
        ev_t e;
        e.cyc  = at;
        e.brk  = brk;
        e.ferr = ferr;
        e.data = data;
        ev_q.push_back(e);
    endtask

    // Drives one 10-bit frame starting at the current negedge and records what it must produce.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int k);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        k = cyc + 1;
        add_event(k + PUSH_LAT, (data == 8'h00) && !stop_bit, !stop_bit, data);
        for (int b = 0; b < 10; b++) begin
            rxd_i = bits[b];
            repeat (CLK_PER_BIT) @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdy_edge <= ready_i;
        rst_edge <= rst_i;
    end

    // Advance the model for the edge just taken, then compare every output.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_edge) begin
                m_q.delete();
                ev_q.delete();
                m_ovr = 1'b0;
                m_brk = 1'b0;
                m_int = 1'b0;
            end else begin
                c_nint = (m_q.size() != 0) || m_ovr || m_brk;
                c_pop  = (m_q.size() != 0) && rdy_edge;
                c_full = (m_q.size() == DEPTH);
                if (c_pop) void'(m_q.pop_front());
                m_ovr = 1'b0;
                m_brk = 1'b0;
                while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
                    c_ev = ev_q.pop_front();
                    if (c_ev.brk)               m_brk = 1'b1;
                    else if (!c_full || c_pop)  m_q.push_back({c_ev.ferr, c_ev.data});
                    else                        m_ovr = 1'b1;
                end
                m_int = c_nint;
            end
            exp_vec = {15'd0, (m_q.size() != 0), 3'(m_q.size()),
                       (m_q.size() != 0) ? m_q[0][7:0] : 8'h00,
                       (m_q.size() != 0) ? m_q[0][8] : 1'b0,
                       1'b0, m_ovr, m_brk, m_int};
            act_vec = {15'd0, valid_o, count_o, dout_o, ferr_o, perr_o, ovr_o, brk_o, int_o};
            check("cycle{valid,count,dout,ferr,perr,ovr,brk,int}", act_vec, exp_vec);

            if (last_valid && rdy_edge) pop_log.push_back(last_dout);
            if (valid_o && !last_valid) rise_cyc = cyc;
            if (ovr_o) ovr_seen++;
            if (brk_o) brk_seen++;
            last_valid = valid_o;
            last_dout  = dout_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, base, n;
        rst_i   = 1'b1;
        rxd_i   = 1'b1;
        ready_i = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_int",   int_o,   0);
        rst_i = 1'b0;
        repeat (20) @(negedge clk);

        // 1: single byte, consumer stalled
        send_frame(8'hA5, 1'b1, k);
        check("t1_latency", rise_cyc - k, 619);
        check("t1_valid", valid_o, 1);
        check("t1_dout",  dout_o,  8'hA5);
        check("t1_ferr",  ferr_o,  0);
        check("t1_count", count_o, 1);
        check("t1_int",   int_o,   1);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        @(negedge clk);
        check("t1_popped", pop_log[pop_log.size()-1], 8'hA5);
        check("t1_empty",  valid_o, 0);

        // 2: short glitch is a false start
        rxd_i = 1'b0;
        repeat (20) @(negedge clk);
        rxd_i = 1'b1;
        repeat (3 * CLK_PER_BIT) @(negedge clk);
        check("t2_valid", valid_o, 0);
        check("t2_count", count_o, 0);

        // 3: bad stop bit, then a clean byte
        send_frame(8'h3C, 1'b0, k);
        rxd_i = 1'b1;
        repeat (CLK_PER_BIT) @(negedge clk);
        send_frame(8'h55, 1'b1, k);
        repeat (10) @(negedge clk);
        check("t3_count", count_o, 2);
        check("t3_dout0", dout_o,  8'h3C);
        check("t3_ferr0", ferr_o,  1);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("t3_dout1", dout_o,  8'h55);
        check("t3_ferr1", ferr_o,  0);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("t3_drained", count_o, 0);

        // 4: six back-to-back bytes into a 4-entry FIFO
        base = ovr_seen;
        for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1, k);
        repeat (20) @(negedge clk);
        check("t4_count", count_o, 4);
        check("t4_ovr_pulses", ovr_seen - base, 2);
        check("t4_head", dout_o, 8'h01);
        ready_i = 1'b1;
        repeat (6) @(negedge clk);
        ready_i = 1'b0;
        n = pop_log.size();
        for (int j = 0; j < 4; j++) check("t4_pop_order", pop_log[n-4+j], j + 1);
        check("t4_drained", count_o, 0);

        // 5: break condition, then recovery
        base  = brk_seen;
        rxd_i = 1'b0;
        k     = cyc + 1;
        add_event(k + PUSH_LAT, 1'b1, 1'b1, 8'h00);
        repeat (20 * CLK_PER_BIT) @(negedge clk);
        rxd_i = 1'b1;
        repeat (CLK_PER_BIT) @(negedge clk);
        check("t5_brk_pulses", brk_seen - base, 1);
        check("t5_no_push", count_o, 0);
        send_frame(8'h7E, 1'b1, k);
        repeat (10) @(negedge clk);
        check("t5_dout",  dout_o,  8'h7E);
        check("t5_count", count_o, 1);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;

        // 6: reset in the middle of a frame with two bytes queued
        send_frame(8'h11, 1'b1, k);
        send_frame(8'h22, 1'b1, k);
        check("t6_queued", count_o, 2);
        rxd_i = 1'b0;
        repeat (CLK_PER_BIT) @(negedge clk);
        rxd_i = 1'b1;
        repeat (100) @(negedge clk);
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("t6_count", count_o, 0);
        check("t6_valid", valid_o, 0);
        repeat (10 * CLK_PER_BIT) @(negedge clk);
        check("t6_no_stale_push", count_o, 0);
        send_frame(8'h81, 1'b1, k);
        repeat (10) @(negedge clk);
        check("t6_dout",  dout_o,  8'h81);
        check("t6_count_after", count_o, 1);

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
